// File: rtl/key_debouncer_pkg.sv
// key_debouncer_pkg
//   Shared constants and the per-channel state encoding for the key debouncer.
//   KEY_IDLE_LEVEL : level of a released (idle) key. The board keys are active-low.
//   db_state_e     : per-channel debounce state (DB_STABLE, DB_COUNTING).
package key_debouncer_pkg;

  localparam logic KEY_IDLE_LEVEL = 1'b1;

  typedef enum logic {
    DB_STABLE   = 1'b0,
    DB_COUNTING = 1'b1
  } db_state_e;

endpackage

// File: rtl/key_debouncer_cell.sv
// key_debouncer_cell
//   One key channel: a 2-flop synchronizer followed by a stability counter.
//   key_clean only changes after the synchronized level has held a new value
//   for DEBOUNCE_CYCLES consecutive clocks.
//   Optional feature macro: KEY_DEBOUNCE_PULSE_EN adds the key_fall press pulse.
// Ports
//   clk       : main clock
//   reset     : synchronous, active-high reset
//   key_raw   : raw asynchronous key level, active-low
//   key_clean : debounced, synchronized level, same polarity as key_raw
//   key_fall  : (KEY_DEBOUNCE_PULSE_EN only) 1-cycle pulse after key_clean goes 1->0
module key_debouncer_cell
  import key_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_clean
`ifdef KEY_DEBOUNCE_PULSE_EN
  ,
  output logic key_fall
`endif
);

  localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 s1;
  logic                 s2;
  logic [CNT_WIDTH-1:0] cnt;
  db_state_e            state;
  logic                 differs;
  logic                 accept;

  // The counter is always zero in DB_STABLE, so one comparison covers both
  // states: in DB_STABLE it only matches when DEBOUNCE_CYCLES == 1, which lets
  // the very first differing sample be accepted immediately.
  assign differs = (s2 != key_clean);
  assign accept  = differs && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1        <= KEY_IDLE_LEVEL;
      s2        <= KEY_IDLE_LEVEL;
      key_clean <= KEY_IDLE_LEVEL;
      cnt       <= '0;
      state     <= DB_STABLE;
    end else begin
      s1 <= key_raw;
      s2 <= s1;
      case (state)
        DB_STABLE: begin
          if (accept) begin
            key_clean <= s2;
          end else if (differs) begin
            state <= DB_COUNTING;
            cnt   <= CNT_ONE;
          end
        end
        DB_COUNTING: begin
          if (!differs) begin
            state <= DB_STABLE;
            cnt   <= '0;
          end else if (accept) begin
            key_clean <= s2;
            cnt       <= '0;
            state     <= DB_STABLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
      endcase
    end
  end

`ifdef KEY_DEBOUNCE_PULSE_EN
  // Pulse in the cycle after a press (idle -> active) is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_fall <= 1'b0;
    end else begin
      key_fall <= accept && (s2 != KEY_IDLE_LEVEL);
    end
  end
`endif

endmodule

// File: rtl/key_debouncer.sv
// key_debouncer
//   Array of NUM_KEYS independent debounce channels for the board push-buttons.
//   Feeds the per-key oneshot edge detectors with clean levels.
//   Optional feature macro: KEY_DEBOUNCE_PULSE_EN adds the key_fall output.
// Ports
//   clk       : main clock (CLOCK_50 domain)
//   reset     : synchronous, active-high reset
//   key_raw   : raw asynchronous key levels, active-low
//   key_clean : debounced, synchronized levels, same polarity as key_raw
//   key_fall  : (KEY_DEBOUNCE_PULSE_EN only) 1-cycle pulse per debounced press
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_clean
`ifdef KEY_DEBOUNCE_PULSE_EN
  ,
  output logic [NUM_KEYS-1:0] key_fall
`endif
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debouncer_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk      (clk),
      .reset    (reset),
      .key_raw  (key_raw[i]),
      .key_clean(key_clean[i])
`ifdef KEY_DEBOUNCE_PULSE_EN
      ,
      .key_fall (key_fall[i])
`endif
    );
  end

endmodule
